thread_registers: RTL

Per-thread register file for one compute-core lane: supplies the `rs`/`rt` operands consumed by the lane's ALU and LSU, and retires results (ALU output, LSU load data, or decoded immediate) back into the destination register. Sixteen 8-bit registers: R0–R12 general purpose, R13–R15 read-only thread context (`%blockIdx`, `%blockDim`, `%threadIdx`). One instance per thread lane, stepped by the core scheduler's `core_state`.

---
 rtl/gpu_pkg.sv | 27 ++
 rtl/thread_registers.sv | 99 +++++++++
 2 files changed

// File: rtl/gpu_pkg.sv
// Shared compute-core definitions: scheduler states, write-source codes
// and the indices of the read-only thread-context registers.
package gpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'b000,
        ST_FETCH   = 3'b001,
        ST_DECODE  = 3'b010,
        ST_REQUEST = 3'b011,
        ST_WAIT    = 3'b100,
        ST_EXECUTE = 3'b101,
        ST_UPDATE  = 3'b110,
        ST_DONE    = 3'b111
    } core_state_t;

    typedef enum logic [1:0] {
        MUX_ALU  = 2'b00,
        MUX_LSU  = 2'b01,
        MUX_IMM  = 2'b10,
        MUX_RSVD = 2'b11
    } reg_mux_t;

    localparam logic [3:0] REG_BLOCK_IDX  = 4'd13;
    localparam logic [3:0] REG_BLOCK_DIM  = 4'd14;
    localparam logic [3:0] REG_THREAD_IDX = 4'd15;

endpackage

// File: rtl/thread_registers.sv
// Per-thread 16-entry register file: R0-R12 general purpose,
// R13-R15 read-only block index / block dim / thread index.
module thread_registers
    import gpu_pkg::*;
#(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int THREAD_ID         = 0,
    parameter int DATA_BITS         = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [7:0]           block_id,
    input  logic [2:0]           core_state,
    input  logic [3:0]           decoded_rd_address,
    input  logic [3:0]           decoded_rs_address,
    input  logic [3:0]           decoded_rt_address,
    input  logic                 decoded_reg_write_enable,
    input  logic [1:0]           decoded_reg_input_mux,
    input  logic [7:0]           decoded_immediate,
    input  logic [7:0]           alu_out,
    input  logic [7:0]           lsu_out,
    output logic [DATA_BITS-1:0] rs,
    output logic [DATA_BITS-1:0] rt,
    output logic                 write_fault
);

    logic [DATA_BITS-1:0] r_regs [16];
    logic [DATA_BITS-1:0] r_rs;
    logic [DATA_BITS-1:0] r_rt;
    logic                 r_fault;

    core_state_t          w_state;
    reg_mux_t             w_mux;
    logic                 w_update;
    logic                 w_ro_target;
    logic                 w_wr_en;
    logic [DATA_BITS-1:0] w_wr_data;

    assign w_state     = core_state_t'(core_state);
    assign w_mux       = reg_mux_t'(decoded_reg_input_mux);
    assign w_update    = (w_state == ST_UPDATE) && decoded_reg_write_enable;
    assign w_ro_target = (decoded_rd_address >= REG_BLOCK_IDX);

    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_data = '0;
        if (w_update && !w_ro_target) begin
            unique case (w_mux)
                MUX_ALU: begin
                    w_wr_en   = 1'b1;
                    w_wr_data = DATA_BITS'(alu_out);
                end
                MUX_LSU: begin
                    w_wr_en   = 1'b1;
                    w_wr_data = DATA_BITS'(lsu_out);
                end
                MUX_IMM: begin
                    w_wr_en   = 1'b1;
                    w_wr_data = DATA_BITS'(decoded_immediate);
                end
                MUX_RSVD: begin
                    w_wr_en   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 14; i++) begin
                r_regs[i] <= '0;
            end
            r_regs[REG_BLOCK_DIM]  <= DATA_BITS'(THREADS_PER_BLOCK);
            r_regs[REG_THREAD_IDX] <= DATA_BITS'(THREAD_ID);
            r_rs    <= '0;
            r_rt    <= '0;
            r_fault <= 1'b0;
        end else if (enable) begin
            // Mirror runs every enabled edge; reads below still see the old R13.
            r_regs[REG_BLOCK_IDX] <= DATA_BITS'(block_id);
            if (w_state == ST_REQUEST) begin
                r_rs <= r_regs[decoded_rs_address];
                r_rt <= r_regs[decoded_rt_address];
            end
            if (w_wr_en) begin
                r_regs[decoded_rd_address] <= w_wr_data;
            end
            if (w_update && w_ro_target) begin
                r_fault <= 1'b1;
            end
        end
    end

    assign rs          = r_rs;
    assign rt          = r_rt;
    assign write_fault = r_fault;

endmodule
